// File: rtl/qmem_cmd_master_pkg.sv
// Shared types and defaults for the qmem command master: FSM state encoding,
// default bus widths and the wait-counter sizing helper.
package qmem_cmd_master_pkg;

  localparam int DEF_QAW = 32;
  localparam int DEF_QDW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RDAT = 2'd2,
    ST_RSP  = 2'd3
  } state_t;

  // A disabled timeout (0) still needs a 1-bit counter to keep the vector legal.
  function automatic int wait_cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/qmem_fifo.sv
// Synchronous command FIFO with full/empty flags; combinational read of the head.
// DEPTH must be a power of two so the pointers wrap naturally.
module qmem_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // alone decide which entries are valid, and a reset-free array maps to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/qmem_cmd_master.sv
// qmem initiator: queues commands, issues each as a qmem cycle and returns one
// in-order response per command, with timeout, sticky error and cycle counters.
module qmem_cmd_master
  import qmem_cmd_master_pkg::*;
#(
  parameter int QAW       = DEF_QAW,
  parameter int QDW       = DEF_QDW,
  parameter int QSW       = QDW / 8,
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_vld,
  output logic           cmd_rdy,
  input  logic           cmd_we,
  input  logic [QSW-1:0] cmd_sel,
  input  logic [QAW-1:0] cmd_adr,
  input  logic [QDW-1:0] cmd_dat,
  output logic           rsp_vld,
  input  logic           rsp_rdy,
  output logic           rsp_we,
  output logic [QDW-1:0] rsp_dat,
  output logic           rsp_err,
  output logic           rsp_tmo,
  output logic           cs,
  output logic           we,
  output logic [QSW-1:0] sel,
  output logic [QAW-1:0] adr,
  output logic [QDW-1:0] dat_w,
  input  logic [QDW-1:0] dat_r,
  input  logic           ack,
  input  logic           err,
  output logic           error,
  output logic [31:0]    w_cnt,
  output logic [31:0]    r_cnt
);

  localparam int CMD_W = 1 + QSW + QAW + QDW;
  localparam int WW    = wait_cnt_width(TIMEOUT);

  typedef struct packed {
    logic           we;
    logic [QDW-1:0] dat;
    logic           err;
    logic           tmo;
  } rsp_t;

  state_t         state, state_nxt;
  logic [CMD_W-1:0] fifo_din, fifo_dout;
  logic           fifo_full, fifo_empty, fifo_push;
  logic           head_we;
  logic [QSW-1:0] head_sel;
  logic [QAW-1:0] head_adr;
  logic [QDW-1:0] head_dat;
  logic [WW-1:0]  wait_cnt;
  logic           wait_hit;
  logic           issue;
  logic           release_bus;
  logic           rsp_load;
  rsp_t           rsp_new;
  logic           inc_w, inc_r;

  // Skid slot: a back-to-back cycle can terminate while the previous response
  // is still unaccepted, so one extra response may need parking.
  logic           skid_vld;
  rsp_t           skid;

  assign fifo_din  = {cmd_we, cmd_sel, cmd_adr, cmd_dat};
  assign fifo_push = cmd_vld && !fifo_full;
  assign cmd_rdy   = !fifo_full;

  assign head_we  = fifo_dout[CMD_W-1];
  assign head_sel = fifo_dout[QAW+QDW +: QSW];
  assign head_adr = fifo_dout[QDW +: QAW];
  assign head_dat = fifo_dout[QDW-1:0];

  qmem_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (issue),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign wait_hit = (TIMEOUT != 0) && (wait_cnt == WW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    issue       = 1'b0;
    release_bus = 1'b0;
    rsp_load    = 1'b0;
    rsp_new     = '0;
    inc_w       = 1'b0;
    inc_r       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && !rsp_vld) begin
          issue     = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (err) begin
          // err wins over a simultaneous ack and still counts as a cycle
          rsp_load    = 1'b1;
          rsp_new.we  = we;
          rsp_new.err = 1'b1;
          inc_w       = we;
          inc_r       = !we;
          release_bus = 1'b1;
          state_nxt   = ST_RSP;
        end else if (ack && we) begin
          rsp_load   = 1'b1;
          rsp_new.we = 1'b1;
          inc_w      = 1'b1;
          if (rsp_rdy && !fifo_empty) begin
            issue = 1'b1;
          end else begin
            release_bus = 1'b1;
            state_nxt   = ST_RSP;
          end
        end else if (ack) begin
          release_bus = 1'b1;
          state_nxt   = ST_RDAT;
        end else if (wait_hit) begin
          rsp_load    = 1'b1;
          rsp_new.we  = we;
          rsp_new.err = 1'b1;
          rsp_new.tmo = 1'b1;
          release_bus = 1'b1;
          state_nxt   = ST_RSP;
        end
      end
      ST_RDAT: begin
        rsp_load    = 1'b1;
        rsp_new.dat = dat_r;
        inc_r       = 1'b1;
        state_nxt   = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_rdy && !skid_vld) begin
          if (!fifo_empty) begin
            issue     = 1'b1;
            state_nxt = ST_REQ;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs       <= 1'b0;
      we       <= 1'b0;
      sel      <= '0;
      adr      <= '0;
      dat_w    <= '0;
      wait_cnt <= '0;
    end else if (issue) begin
      cs       <= 1'b1;
      we       <= head_we;
      sel      <= head_sel;
      adr      <= head_adr;
      dat_w    <= head_dat;
      wait_cnt <= '0;
    end else if (release_bus) begin
      cs <= 1'b0;
    end else if (state == ST_REQ && TIMEOUT != 0 && !wait_hit) begin
      wait_cnt <= wait_cnt + WW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld  <= 1'b0;
      rsp_we   <= 1'b0;
      rsp_dat  <= '0;
      rsp_err  <= 1'b0;
      rsp_tmo  <= 1'b0;
      skid_vld <= 1'b0;
      skid     <= '0;
    end else if (rsp_load) begin
      if (!rsp_vld || rsp_rdy) begin
        rsp_vld <= 1'b1;
        rsp_we  <= rsp_new.we;
        rsp_dat <= rsp_new.dat;
        rsp_err <= rsp_new.err;
        rsp_tmo <= rsp_new.tmo;
      end else begin
        skid_vld <= 1'b1;
        skid     <= rsp_new;
      end
    end else if (rsp_vld && rsp_rdy) begin
      if (skid_vld) begin
        rsp_we   <= skid.we;
        rsp_dat  <= skid.dat;
        rsp_err  <= skid.err;
        rsp_tmo  <= skid.tmo;
        skid_vld <= 1'b0;
      end else begin
        rsp_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      error <= 1'b0;
      w_cnt <= '0;
      r_cnt <= '0;
    end else begin
      if (rsp_load && rsp_new.err) error <= 1'b1;
      if (inc_w) w_cnt <= w_cnt + 32'd1;
      if (inc_r) r_cnt <= r_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_qmem_cmd_master.sv
// Directed bench for qmem_cmd_master: write, waited read, back-to-back writes,
// timeout, ack+err collision, full FIFO and reset during a transfer.
module tb_qmem_cmd_master;

  localparam int QAW = 32;
  localparam int QDW = 32;
  localparam int QSW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cmd_vld = 1'b0;
  logic           cmd_rdy;
  logic           cmd_we = 1'b0;
  logic [QSW-1:0] cmd_sel = '0;
  logic [QAW-1:0] cmd_adr = '0;
  logic [QDW-1:0] cmd_dat = '0;
  logic           rsp_vld;
  logic           rsp_rdy = 1'b0;
  logic           rsp_we;
  logic [QDW-1:0] rsp_dat;
  logic           rsp_err;
  logic           rsp_tmo;
  logic           cs;
  logic           we;
  logic [QSW-1:0] sel;
  logic [QAW-1:0] adr;
  logic [QDW-1:0] dat_w;
  logic [QDW-1:0] dat_r = '0;
  logic           ack = 1'b0;
  logic           err = 1'b0;
  logic           error;
  logic [31:0]    w_cnt;
  logic [31:0]    r_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  int cs_cnt, cs_first, cs_last, rsp_cnt, smp;
  logic [QAW-1:0] adr_seen [8];

  always #5 clk = ~clk;

  qmem_cmd_master #(
    .QAW (QAW), .QDW (QDW), .QSW (QSW), .CMD_DEPTH (4), .TIMEOUT (8)
  ) dut (
    .clk (clk), .rst (rst),
    .cmd_vld (cmd_vld), .cmd_rdy (cmd_rdy), .cmd_we (cmd_we),
    .cmd_sel (cmd_sel), .cmd_adr (cmd_adr), .cmd_dat (cmd_dat),
    .rsp_vld (rsp_vld), .rsp_rdy (rsp_rdy), .rsp_we (rsp_we),
    .rsp_dat (rsp_dat), .rsp_err (rsp_err), .rsp_tmo (rsp_tmo),
    .cs (cs), .we (we), .sel (sel), .adr (adr), .dat_w (dat_w),
    .dat_r (dat_r), .ack (ack), .err (err),
    .error (error), .w_cnt (w_cnt), .r_cnt (r_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_vld = 1'b0; rsp_rdy = 1'b0; ack = 1'b0; err = 1'b0; dat_r = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic push_cmd(input logic w, input logic [QSW-1:0] s,
                          input logic [QAW-1:0] a, input logic [QDW-1:0] d);
    cmd_we = w; cmd_sel = s; cmd_adr = a; cmd_dat = d; cmd_vld = 1'b1;
    for (int i = 0; i < 20 && !cmd_rdy; i++) tick();
    check("push_rdy", cmd_rdy, 1);
    tick();
    cmd_vld = 1'b0;
  endtask

  task automatic wait_cs(input string tag);
    for (int i = 0; i < 20 && !cs; i++) tick();
    check({tag, "_cs_seen"}, cs, 1);
  endtask

  task automatic mon_b2b();
    if (cs) begin
      if (cs_cnt == 0) cs_first = smp;
      cs_last = smp;
      if (cs_cnt < 8) adr_seen[cs_cnt] = adr;
      cs_cnt++;
    end
    if (rsp_vld && rsp_rdy) rsp_cnt++;
    smp++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    do_reset();

    // reset state
    check("rst_cs", cs, 0);
    check("rst_cmd_rdy", cmd_rdy, 1);
    check("rst_rsp_vld", rsp_vld, 0);
    check("rst_error", error, 0);
    check("rst_adr", adr, 0);
    check("rst_cnts", {w_cnt, r_cnt}, 0);

    // 1: zero-wait write
    push_cmd(1'b1, 4'hF, 32'h100, 32'hDEADBEEF);
    wait_cs("t1");
    check("t1_adr", adr, 32'h100);
    check("t1_we", we, 1);
    check("t1_sel", sel, 4'hF);
    check("t1_dat_w", dat_w, 32'hDEADBEEF);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t1_cs_one_cycle", cs, 0);
    check("t1_rsp_vld", rsp_vld, 1);
    check("t1_rsp_we", rsp_we, 1);
    check("t1_rsp_err", rsp_err, 0);
    check("t1_w_cnt", w_cnt, 1);
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    check("t1_rsp_done", rsp_vld, 0);

    // 2: read with 3 wait cycles, data the cycle after ack
    do_reset();
    push_cmd(1'b0, 4'hF, 32'h104, 32'h0);
    wait_cs("t2");
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cs) n++;
    end
    check("t2_cs_held", n, 3);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    dat_r = 32'h12345678;
    check("t2_rdat_cs", cs, 0);
    check("t2_rdat_no_rsp", rsp_vld, 0);
    tick();
    dat_r = 32'h0;
    check("t2_rsp_vld", rsp_vld, 1);
    check("t2_rsp_dat", rsp_dat, 32'h12345678);
    check("t2_rsp_we", rsp_we, 0);
    check("t2_rsp_err", rsp_err, 0);
    check("t2_r_cnt", r_cnt, 1);
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;

    // 3: four back-to-back writes, zero-wait slave, consumer always ready
    do_reset();
    ack = 1'b1; rsp_rdy = 1'b1;
    cs_cnt = 0; cs_first = 0; cs_last = 0; rsp_cnt = 0; smp = 0;
    for (int i = 0; i < 4; i++) begin
      push_cmd(1'b1, 4'hF, 32'h200 + 32'(4 * i), 32'hA0 + 32'(i));
      mon_b2b();
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      mon_b2b();
    end
    ack = 1'b0; rsp_rdy = 1'b0;
    check("t3_cs_cycles", cs_cnt, 4);
    check("t3_cs_continuous", cs_last - cs_first + 1, 4);
    for (int i = 0; i < 4; i++) check("t3_adr_order", adr_seen[i], 32'h200 + 32'(4 * i));
    check("t3_rsp_count", rsp_cnt, 4);
    check("t3_w_cnt", w_cnt, 4);

    // 4: slave never answers, TIMEOUT=8
    do_reset();
    push_cmd(1'b0, 4'h3, 32'h300, 32'h0);
    wait_cs("t4");
    n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!cs) break;
      n++;
    end
    check("t4_req_cycles", n, 9);
    check("t4_rsp_vld", rsp_vld, 1);
    check("t4_rsp_tmo", rsp_tmo, 1);
    check("t4_rsp_err", rsp_err, 1);
    check("t4_rsp_dat", rsp_dat, 0);
    check("t4_error", error, 1);
    check("t4_cnts", {w_cnt, r_cnt}, 0);
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;

    // 5: ack and err in the same cycle
    do_reset();
    check("t5_error_clear", error, 0);
    push_cmd(1'b1, 4'h1, 32'h400, 32'h55);
    wait_cs("t5");
    ack = 1'b1; err = 1'b1;
    tick();
    ack = 1'b0; err = 1'b0;
    check("t5_cs", cs, 0);
    check("t5_rsp_vld", rsp_vld, 1);
    check("t5_rsp_err", rsp_err, 1);
    check("t5_rsp_tmo", rsp_tmo, 0);
    check("t5_error", error, 1);
    check("t5_w_cnt", w_cnt, 1);
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    tick();
    check("t5_error_sticky", error, 1);

    // 6: response stalled, FIFO fills, then reset while a cycle is in REQ
    do_reset();
    ack = 1'b1;
    for (int i = 0; i < 5; i++) push_cmd(1'b1, 4'hF, 32'h500 + 32'(4 * i), 32'(i));
    check("t6_full", cmd_rdy, 0);
    ack = 1'b0;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cs) n++;
    end
    check("t6_no_cs", n, 0);
    check("t6_rsp_pending", rsp_vld, 1);
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    check("t6_reissue_cs", cs, 1);
    check("t6_reissue_adr", adr, 32'h504);
    check("t6_rdy_again", cmd_rdy, 1);
    rst = 1'b1;
    tick();
    check("t6_rst_cs", cs, 0);
    check("t6_rst_bus", {we, sel, adr, dat_w}, 0);
    check("t6_rst_rsp", {rsp_vld, rsp_err, rsp_tmo, error}, 0);
    check("t6_rst_cnts", {w_cnt, r_cnt}, 0);
    check("t6_rst_cmd_rdy", cmd_rdy, 1);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cs || rsp_vld) n++;
    end
    check("t6_fifo_flushed", n, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
